// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state type, constants and round helper for the AES round controller
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_RIDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARK0,
        ST_SUB,
        ST_SHIFT,
        ST_MIX,
        ST_ARK,
        ST_DONE
    } aes_rnd_state_t;

    // Encrypt counts rounds up to nr, decrypt counts down to 0.
    function automatic logic last_round(input logic [AES_RIDX_W-1:0] r,
                                        input logic                  dec,
                                        input logic [AES_RIDX_W-1:0] nr);
        return dec ? (r == '0) : (r == nr);
    endfunction

endpackage

// File: rtl/aes_lat_timer.sv
// rtl/aes_lat_timer.sv - loadable down-counter with zero flag, shared by the SUB and MIX waits
module aes_lat_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer issuing datapath strobes; AES_DEC_EN adds decrypt ordering
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int SUB_LAT = 1,
    parameter int MIX_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_dec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ark_en,
    output logic                  sub_en,
    output logic                  shift_en,
    output logic                  col_mix_en,
    output logic [AES_RIDX_W-1:0] round_idx,
    output logic                  inv_mode,
    output logic                  busy
);

    localparam int MAX_LAT = (SUB_LAT > MIX_LAT) ? SUB_LAT : MIX_LAT;
    localparam int TW      = $clog2(MAX_LAT) + 1;
    localparam logic [TW-1:0]         SUB_LOAD = TW'(SUB_LAT - 1);
    localparam logic [TW-1:0]         MIX_LOAD = TW'(MIX_LAT - 1);
    localparam logic [AES_RIDX_W-1:0] NR_W     = AES_RIDX_W'(NR);

    aes_rnd_state_t        state_q, state_d;
    logic [AES_RIDX_W-1:0] r_q;
    logic [AES_RIDX_W-1:0] round_idx_q;
    logic                  ark_en_q, sub_en_q, shift_en_q, col_mix_en_q;
    logic                  out_valid_q, in_ready_q, busy_q;
    logic                  dec, dec_acc;
    logic                  enter;
    logic                  tmr_zero;
    logic [TW-1:0]         tmr_val;

`ifdef AES_DEC_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (state_q == ST_IDLE && in_valid) begin
            inv_q <= in_dec;
        end
    end

    assign dec     = inv_q;
    assign dec_acc = in_dec;
`else
    logic unused_in_dec;
    assign unused_in_dec = in_dec;
    assign dec           = 1'b0;
    assign dec_acc       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_ARK0;
            ST_ARK0:  state_d = dec ? ST_SHIFT : ST_SUB;
            ST_SUB:   if (tmr_zero) state_d = dec ? ST_ARK : ST_SHIFT;
            ST_SHIFT: begin
                if (dec) begin
                    state_d = ST_SUB;
                end else begin
                    state_d = last_round(r_q, dec, NR_W) ? ST_ARK : ST_MIX;
                end
            end
            ST_MIX:   if (tmr_zero) state_d = dec ? ST_SHIFT : ST_ARK;
            ST_ARK:   state_d = last_round(r_q, dec, NR_W) ? ST_DONE
                                                           : (dec ? ST_MIX : ST_SUB);
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The timer reloads on every state change; only SUB and MIX look at it.
    assign enter   = (state_d != state_q);
    assign tmr_val = (state_d == ST_SUB) ? SUB_LOAD :
                     (state_d == ST_MIX) ? MIX_LOAD : '0;

    aes_lat_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (enter),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            r_q          <= '0;
            round_idx_q  <= '0;
            ark_en_q     <= 1'b0;
            sub_en_q     <= 1'b0;
            shift_en_q   <= 1'b0;
            col_mix_en_q <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ark_en_q     <= enter && (state_d == ST_ARK0 || state_d == ST_ARK);
            sub_en_q     <= enter && (state_d == ST_SUB);
            shift_en_q   <= enter && (state_d == ST_SHIFT);
            col_mix_en_q <= enter && (state_d == ST_MIX);
            out_valid_q  <= (state_d == ST_DONE);
            in_ready_q   <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            // r_q always holds the key index the next ARK will present.
            if (state_q == ST_IDLE && in_valid) begin
                round_idx_q <= dec_acc ? NR_W : '0;
                r_q         <= dec_acc ? (NR_W - 1'b1) : AES_RIDX_W'(1);
            end
            if (enter && state_d == ST_ARK) begin
                round_idx_q <= r_q;
            end
            if (state_q == ST_ARK && state_d != ST_DONE) begin
                r_q <= dec ? (r_q - 1'b1) : (r_q + 1'b1);
            end
        end
    end

    assign ark_en     = ark_en_q;
    assign sub_en     = sub_en_q;
    assign shift_en   = shift_en_q;
    assign col_mix_en = col_mix_en_q;
    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign round_idx  = round_idx_q;
    assign inv_mode   = dec;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed bench for aes_round_ctrl (default and SUB_LAT=2/MIX_LAT=3 instances)
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid1, in_valid2, in_dec, out_ready;

    logic       in_ready1, out_valid1, ark1, sub1, shift1, mix1, inv1, busy1;
    logic [3:0] ridx1;
    logic       in_ready2, out_valid2, ark2, sub2, shift2, mix2, inv2, busy2;
    logic [3:0] ridx2;

    always #5 clk = ~clk;

    aes_round_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_dec     (in_dec),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .ark_en     (ark1),
        .sub_en     (sub1),
        .shift_en   (shift1),
        .col_mix_en (mix1),
        .round_idx  (ridx1),
        .inv_mode   (inv1),
        .busy       (busy1)
    );

    aes_round_ctrl #(.SUB_LAT(2), .MIX_LAT(3)) u_dut_lat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_dec     (in_dec),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .ark_en     (ark2),
        .sub_en     (sub2),
        .shift_en   (shift2),
        .col_mix_en (mix2),
        .round_idx  (ridx2),
        .inv_mode   (inv2),
        .busy       (busy2)
    );

    logic       sel;
    logic       s_ark, s_sub, s_shift, s_mix, s_out_valid, s_in_ready, s_inv, s_busy;
    logic [3:0] s_ridx;

    assign s_ark       = sel ? ark2       : ark1;
    assign s_sub       = sel ? sub2       : sub1;
    assign s_shift     = sel ? shift2     : shift1;
    assign s_mix       = sel ? mix2       : mix1;
    assign s_out_valid = sel ? out_valid2 : out_valid1;
    assign s_in_ready  = sel ? in_ready2  : in_ready1;
    assign s_inv       = sel ? inv2       : inv1;
    assign s_busy      = sel ? busy2      : busy1;
    assign s_ridx      = sel ? ridx2      : ridx1;

    int checks = 0;
    int errors = 0;

    int n_ark, n_sub, n_shift, n_mix, k_out, k_ark_first, k_ark_last;
    int mix_consec, mix_after_ark_bad, inv_bad, gap_bad, k_last_mix;
    int ridx_seq [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse one accept, then follow the block cycle by cycle until out_valid rises.
    task automatic run_block(input logic dec, input logic ordy, input int exp_gap, input logic exp_inv);
        logic prev_mix, prev_ark;
        n_ark = 0; n_sub = 0; n_shift = 0; n_mix = 0; k_out = -1;
        k_ark_first = -1; k_ark_last = -1; mix_consec = 0; mix_after_ark_bad = 0;
        inv_bad = 0; gap_bad = 0; k_last_mix = 0;
        prev_mix = 1'b0; prev_ark = 1'b0;
        for (int i = 0; i < 16; i++) ridx_seq[i] = -1;
        out_ready = ordy;
        in_dec    = dec;
        if (sel) in_valid2 = 1'b1; else in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (s_ark) begin
                if (n_ark == 0) k_ark_first = k;
                k_ark_last = k;
                if (n_ark < 16) ridx_seq[n_ark] = int'(s_ridx);
                n_ark++;
            end
            if (s_sub) n_sub++;
            if (s_shift) begin
                n_shift++;
                if (k_last_mix > 0 && (k - k_last_mix) != exp_gap) gap_bad++;
                k_last_mix = 0;
            end
            if (s_mix) begin
                n_mix++;
                if (prev_mix) mix_consec++;
                if (!prev_ark) mix_after_ark_bad++;
                k_last_mix = k;
            end
            if (s_inv !== exp_inv) inv_bad++;
            prev_mix = s_mix;
            prev_ark = s_ark;
            if (s_out_valid) begin
                k_out = k;
                break;
            end
            tick();
        end
    endtask

    function automatic int ridx_bad(input logic dec);
        int bad = 0;
        for (int i = 0; i <= 10; i++) begin
            if (ridx_seq[i] != (dec ? 10 - i : i)) bad++;
        end
        return bad;
    endfunction

    initial begin
        int found;
        int hold_bad;
        sel       = 1'b0;
        rst_n     = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_dec    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_strobes", {ark1, sub1, shift1, mix1}, 0);
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_round_idx", ridx1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_inv_mode", inv1, 0);
        rst_n = 1'b1;
        tick();

        // Encrypt, default latencies
        run_block(1'b0, 1'b1, 3, 1'b0);
        chk("enc_ark_cnt", n_ark, 11);
        chk("enc_sub_cnt", n_sub, 10);
        chk("enc_shift_cnt", n_shift, 10);
        chk("enc_mix_cnt", n_mix, 9);
        chk("enc_mix_consec", mix_consec, 0);
        chk("enc_ark_first", k_ark_first, 1);
        chk("enc_ark_last", k_ark_last, 40);
        chk("enc_ridx_seq_bad", ridx_bad(1'b0), 0);
        chk("enc_mix_to_shift_gap_bad", gap_bad, 0);
        chk("enc_out_cycle", k_out, 41);
        tick();
        chk("enc_out_valid_1cyc", out_valid1, 0);
        chk("enc_in_ready_after", in_ready1, 1);

        // Backpressure
        run_block(1'b0, 1'b0, 3, 1'b0);
        chk("bp_out_cycle", k_out, 41);
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || {ark1, sub1, shift1, mix1} !== 4'b0)
                hold_bad++;
        end
        chk("bp_hold_bad", hold_bad, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready", in_ready1, 1);
        chk("bp_out_valid_drop", out_valid1, 0);
        chk("bp_busy", busy1, 0);

        // Longer unit latencies
        sel = 1'b1;
        run_block(1'b0, 1'b1, 6, 1'b0);
        chk("lat_out_cycle", k_out, 69);
        chk("lat_mix_cnt", n_mix, 9);
        chk("lat_mix_consec", mix_consec, 0);
        chk("lat_mix_to_shift_gap_bad", gap_bad, 0);
        chk("lat_ark_cnt", n_ark, 11);
        chk("lat_shift_cnt", n_shift, 10);
        chk("lat_ridx_seq_bad", ridx_bad(1'b0), 0);
        tick();
        chk("lat_in_ready_after", in_ready2, 1);
        sel = 1'b0;

        // Reset mid-block while round_idx=5
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        found = 0;
        for (int k = 1; k <= 60; k++) begin
            if (ark1 && ridx1 == 4'd5) begin
                found = k;
                break;
            end
            tick();
        end
        chk("mid_rst_ridx5_cycle", found, 21);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {ark1, sub1, shift1, mix1}, 0);
        chk("mid_rst_round_idx", ridx1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_in_ready", in_ready1, 1);
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid1 !== 1'b0) hold_bad++;
        end
        chk("mid_rst_out_valid", hold_bad, 0);
        rst_n = 1'b1;
        tick();
        run_block(1'b0, 1'b1, 3, 1'b0);
        chk("post_rst_out_cycle", k_out, 41);
        chk("post_rst_ark_cnt", n_ark, 11);
        tick();

`ifdef AES_DEC_EN
        run_block(1'b1, 1'b1, 1, 1'b1);
        chk("dec_inv_bad", inv_bad, 0);
        chk("dec_ridx_seq_bad", ridx_bad(1'b1), 0);
        chk("dec_mix_after_ark_bad", mix_after_ark_bad, 0);
        chk("dec_mix_cnt", n_mix, 9);
        chk("dec_ark_cnt", n_ark, 11);
        chk("dec_out_cycle", k_out, 41);
`else
        run_block(1'b1, 1'b1, 3, 1'b0);
        chk("nodec_inv_bad", inv_bad, 0);
        chk("nodec_ridx_seq_bad", ridx_bad(1'b0), 0);
        chk("nodec_out_cycle", k_out, 41);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
